vec_issue_queue: RTL
====================

# vec_issue_queue

Instruction buffer and issue sequencer directly upstream of the vector pipeline's `insn_in` port. It accepts 32-bit RVV instructions from the scalar core with a valid/ready handshake and buffers them in a FIFO. It drives one instruction per cycle into the pipeline, emitting all-zero NOPs when idle. It snoops `vset{i}vli` to track LMUL and holds each vector-arithmetic instruction on `insn_out` for one cycle per register of its group, incrementing a group index.

## Interface
- `INSN_WIDTH`, 32, instruction width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `PTR_W`, $clog2(DEPTH), pointer width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `insn_in`  in  INSN_WIDTH  instruction from scalar core
- `insn_in_valid`  in  1  `insn_in` is valid
- `insn_in_ready`  out  1  queue can accept; equals `~full`
- `stall_in`  in  1  pipeline stall; freezes issue
- `insn_out`  out  INSN_WIDTH  instruction to pipeline; 0 = NOP
- `insn_out_valid`  out  1  `insn_out` is a real instruction
- `grp_idx`  out  3  register index within current LMUL group
- `cur_vlmul`  out  3  currently tracked vlmul
- `count`  out  PTR_W+1  FIFO occupancy
- `queue_empty`  out  1  count == 0

## Operation
- Push occurs when `insn_in_valid & insn_in_ready`. Ready depends only on `full`, so there is no combinational path from issue logic.
- FSM states:
  - IDLE: output is NOP.
    - If not stalled and the FIFO is non-empty, pop the head into `insn_out` and go to ISSUE.
  - ISSUE: the output register holds an instruction.
    - If stalled: hold everything.
    - Else if `grp_idx+1 < G`: increment `grp_idx`; the instruction stays on the output.
    - Else if the FIFO is non-empty: pop the next instruction, set `grp_idx`=0, remain in ISSUE.
    - Else: load NOP, go to IDLE.
- Group count G for the loaded instruction:
  - G = 1<<vlmul when opcode[6:0]==7'h57, funct3 != 3'h7, and vlmul ∈ {0..3}.
  - G = 1 for fractional vlmul (4..7), for config instructions, and for all other opcodes.
- vlmul snoop at the edge that loads a config instruction (opcode 7'h57, funct3 7):
  - `vsetvli` (bit31=0) and `vsetivli` (bits31:30=2'b11): vlmul ← insn[22:20].
  - `vsetvl` (bits31:30=2'b10): vlmul unchanged.
  - The next instruction loaded uses the new vlmul.
- G is computed when an instruction is loaded and held in a register. vlmul changes never alter an in-flight group.
- Simultaneous push and pop: occupancy is unchanged. When full with a pop in the same cycle, the push is still refused.
- No bypass: an instruction pushed into an empty FIFO reaches the output no earlier than the next edge.

## Timing
- Reset values: `insn_out`=0, `insn_out_valid`=0, `grp_idx`=0, `cur_vlmul`=0, `count`=0, `queue_empty`=1, `insn_in_ready`=1. Pointers cleared and FSM=IDLE.
- Reset asserted mid-operation: all queued instructions are discarded and outputs return to reset values asynchronously.
- Latency: push at edge N puts the instruction on `insn_out` after edge N+1 when the queue is idle.
- Throughput: one instruction per cycle for G=1. A group of G occupies G consecutive unstalled cycles.
- `stall_in` is sampled at the edge. While it is high, `insn_out`, `insn_out_valid` and `grp_idx` are frozen and no pop occurs; pushes continue.
- `insn_out_valid` = (state==ISSUE). All outputs are registered except `insn_in_ready` and `queue_empty`, which are decoded from registered `count`.
- Pointers wrap modulo DEPTH; full is detected via the extra count bit.

## Structure
- Package `vec_pkg` holds: `OP_V`=7'h57, `F3_CFG`=3'h7, `NOP_INSN`=0, the state enum {IDLE, ISSUE}, and function `grp_size(vlmul)`.
- One sub-module, `insn_fifo`: synchronous FIFO (DEPTH, width) with push/pop/full/empty/count.
- The FSM, group counter and vlmul tracker live in the top.

## Test plan
- Reset: after reset, push 3 ALU instructions (vlmul=0) back-to-back → `insn_out` shows each for one cycle starting the edge after the first push; `grp_idx`=0 throughout; NOP afterward with `valid`=0.
- Grouping: push `vsetivli` with vlmul=2, then `vadd.vv`. Expected: `cur_vlmul`=2; `vadd` held 4 cycles with `grp_idx` 0,1,2,3; next instruction follows immediately.
- Fractional / `vsetvl`:
  - `vsetvli` with vlmul=5 followed by `vadd` → G=1.
  - `vsetvl` → `cur_vlmul` unchanged.
  - Load opcode 7'h07 under vlmul=3 → G=1.
- Full: stall and push 8 instructions → `count`=8, `ready`=0. A 9th push is refused. Releasing the stall drains all 8 in order.
- Stall mid-group: vlmul=1, stall at `grp_idx`=0 for 3 cycles → output frozen; `grp_idx`=1 occurs after the stall lifts.
- Async reset mid-group: reset asserted → `insn_out`=0 immediately. After release, `count`=0 and `cur_vlmul`=0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants, FSM state type and group-size helper for the vector issue queue.
package vec_pkg;

  localparam logic [6:0]  OP_V     = 7'h57;
  localparam logic [2:0]  F3_CFG   = 3'h7;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Number of registers in an LMUL group; fractional settings (vlmul[2]=1) occupy one register.
  function automatic logic [3:0] grp_size(input logic [2:0] vlmul);
    return vlmul[2] ? 4'd1 : (4'd1 << vlmul);
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Synchronous instruction FIFO with an extra count bit so full and empty are distinguishable.
module insn_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

  // Storage array needs no reset: the pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vec_issue_queue.sv
// Instruction buffer and issue sequencer feeding the vector pipeline, with LMUL group replay.
module vec_issue_queue
  import vec_pkg::*;
#(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic                  insn_in_valid,
  output logic                  insn_in_ready,
  input  logic                  stall_in,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_out_valid,
  output logic [2:0]            grp_idx,
  output logic [2:0]            cur_vlmul,
  output logic [PTR_W:0]        count,
  output logic                  queue_empty
);

  state_t                r_state;
  logic [INSN_WIDTH-1:0] r_insnOut;
  logic [2:0]            r_grpIdx;
  logic [3:0]            r_grpSize;
  logic [2:0]            r_vlmul;

  logic [INSN_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_groupDone;
  logic                  w_headIsV;
  logic                  w_headIsCfg;
  logic                  w_headSetsLmul;
  logic [3:0]            w_headGrp;

  assign w_push         = insn_in_valid & ~w_full;
  assign w_groupDone    = (({1'b0, r_grpIdx} + 4'd1) >= r_grpSize);
  assign w_pop          = ~stall_in & ~w_empty & ((r_state == IDLE) | w_groupDone);
  assign w_headIsV      = (w_head[6:0] == OP_V);
  assign w_headIsCfg    = w_headIsV & (w_head[14:12] == F3_CFG);
  assign w_headSetsLmul = w_headIsCfg & (~w_head[31] | w_head[30]);
  assign w_headGrp      = (w_headIsV & ~w_headIsCfg) ? grp_size(r_vlmul) : 4'd1;

  insn_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (insn_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Issue FSM: load a new head when the current group is finished, otherwise step the group index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_insnOut <= INSN_WIDTH'(NOP_INSN);
      r_grpIdx  <= '0;
      r_grpSize <= 4'd1;
      r_vlmul   <= '0;
    end else if (w_pop) begin
      r_state   <= ISSUE;
      r_insnOut <= w_head;
      r_grpIdx  <= '0;
      r_grpSize <= w_headGrp;
      if (w_headSetsLmul) r_vlmul <= w_head[22:20];
    end else if (!stall_in && r_state == ISSUE) begin
      if (!w_groupDone) begin
        r_grpIdx <= r_grpIdx + 3'd1;
      end else begin
        r_state   <= IDLE;
        r_insnOut <= INSN_WIDTH'(NOP_INSN);
        r_grpIdx  <= '0;
        r_grpSize <= 4'd1;
      end
    end
  end

  assign insn_out       = r_insnOut;
  assign insn_out_valid = (r_state == ISSUE);
  assign grp_idx        = r_grpIdx;
  assign cur_vlmul      = r_vlmul;
  assign insn_in_ready  = ~w_full;
  assign queue_empty    = w_empty;

endmodule
